pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_capture_if.sv | 47 ++++
 rtl/pwm_in_sync.sv | 46 ++++
 rtl/pwm_capture.sv | 171 +++++++++++++++++
 tb/tb_pwm_capture.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and capture state type for the PWM blocks
//
// Purpose : common defaults and the input-capture FSM state encoding, shared
//           by the capture top, its interface and the pad synchronizer.
// Ports   : none (package)
package pwm_pkg;

  // Default width of prescaler, period and high-time counters/results.
  localparam int PWM_CNT_WIDTH = 8;

  // Default depth of the pad-input synchronizer (must be 2 or more).
  localparam int PWM_SYNC_STAGES = 2;

  // Input-capture states:
  //   IDLE - disabled, nothing tracked
  //   ARM  - enabled, waiting for the first rising edge to start a period
  //   HIGH - inside the high phase of a measured period
  //   LOW  - inside the low phase of a measured period
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } capture_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - control inputs and measurement results of pwm_capture
//
// Purpose : groups the capture block's control, pad input and result nets.
// Signals : enable      - capture enable; low forces the block idle
//           prescaler   - one tick every prescaler+1 clocks
//           pwm_in      - asynchronous PWM level from the input pad
//           period_meas - ticks from one rising edge to the next
//           high_meas   - ticks from rising edge to falling edge
//           meas_valid  - one-cycle strobe, new results present
//           timeout     - one-cycle strobe, period counter saturated
// Modports: master - the side that drives control and consumes results
//           slave  - the capture block itself
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = PWM_CNT_WIDTH
);

  logic                 enable;
  logic [CNT_WIDTH-1:0] prescaler;
  logic                 pwm_in;
  logic [CNT_WIDTH-1:0] period_meas;
  logic [CNT_WIDTH-1:0] high_meas;
  logic                 meas_valid;
  logic                 timeout;

  modport master (
    output enable,
    output prescaler,
    output pwm_in,
    input  period_meas,
    input  high_meas,
    input  meas_valid,
    input  timeout
  );

  modport slave (
    input  enable,
    input  prescaler,
    input  pwm_in,
    output period_meas,
    output high_meas,
    output meas_valid,
    output timeout
  );

endinterface

// File: rtl/pwm_in_sync.sv
// rtl/pwm_in_sync.sv - pad-input synchronizer with registered edge strobes
//
// Purpose : brings an asynchronous pad level into the clk domain through a
//           SYNC_STAGES flop chain, then an edge-detect register producing
//           one-cycle rise/fall strobes. Usable for any pad input.
// Ports   : clk   - core clock
//           reset - synchronous, active-high reset
//           din   - asynchronous input level
//           level - synchronized level (edge-detect register)
//           rise  - one-cycle strobe, level went 0 -> 1
//           fall  - one-cycle strobe, level went 1 -> 0
module pwm_in_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // The strobes are registered so every downstream consumer sees flop
  // outputs only; this adds one clock to the pad-to-strobe latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      level  <= sync_out;
      rise   <= sync_out & ~level;
      fall   <= ~sync_out & level;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM input capture: period and high time in prescaled ticks
//
// Purpose : measures an external PWM waveform. Each completed cycle reports
//           period_meas/high_meas with a one-cycle meas_valid strobe; a
//           period that overflows the counter gives a one-cycle timeout.
// Ports   : clk   - core clock
//           reset - synchronous, active-high reset
//           bus   - pwm_capture_if.slave: enable, prescaler, pwm_in in;
//                   period_meas, high_meas, meas_valid, timeout out
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH   = PWM_CNT_WIDTH,
  parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         reset,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // The synchronized level is available for other pad users; capture
  // itself works purely from the edge strobes.
  logic unused_level;
  logic rise;
  logic fall;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pwm_in_sync (
    .clk  (clk),
    .reset(reset),
    .din  (bus.pwm_in),
    .level(unused_level),
    .rise (rise),
    .fall (fall)
  );

  capture_state_e       state_q, state_d;
  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d, pcnt_run;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_run;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic [CNT_WIDTH-1:0] period_meas_q, period_meas_d;
  logic [CNT_WIDTH-1:0] high_meas_q, high_meas_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 tick;
  logic                 saturate;

  // Tick and free-running counter updates. A rising edge realigns the
  // prescaler phase: the rise cycle itself is the first clock of the new
  // span, so it only ticks when every clock is a tick. This makes a span
  // of N clocks count exactly floor(N/(prescaler+1)) ticks.
  always_comb begin : tick_gen
    tick     = 1'b0;
    pcnt_run = pcnt_q;
    cnt_run  = cnt_q;
    if (rise) begin
      tick     = (bus.prescaler == '0);
      pcnt_run = tick ? '0 : CNT_ONE;
      cnt_run  = tick ? CNT_ONE : '0;
    end else begin
      tick     = (pcnt_q == bus.prescaler);
      pcnt_run = tick ? '0 : pcnt_q + CNT_ONE;
      cnt_run  = cnt_q + (tick ? CNT_ONE : '0);
    end
  end

  // The next tick would wrap the period counter. A rise in the same cycle
  // wins, so a published period can reach CNT_MAX but never wraps.
  assign saturate = !rise && tick && (cnt_q == CNT_MAX);

  always_comb begin : fsm_next
    state_d       = state_q;
    pcnt_d        = pcnt_run;
    cnt_d         = cnt_run;
    high_d        = high_q;
    period_meas_d = period_meas_q;
    high_meas_d   = high_meas_q;
    meas_valid_d  = 1'b0;
    timeout_d     = 1'b0;

    if (!bus.enable) begin
      state_d = IDLE;
      pcnt_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          pcnt_d  = '0;
          cnt_d   = '0;
        end

        // First edge only starts a period; cnt_run already holds the
        // restarted count for the rise cycle.
        ARM: begin
          if (rise) begin
            state_d = HIGH;
          end else begin
            cnt_d = '0;
          end
        end

        // A rise while still HIGH means the low phase was too short to be
        // sampled: report the whole period as high time.
        HIGH: begin
          if (rise) begin
            period_meas_d = cnt_q;
            high_meas_d   = cnt_q;
            meas_valid_d  = 1'b1;
          end else if (saturate) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARM;
          end else if (fall) begin
            high_d  = cnt_q;
            state_d = LOW;
          end
        end

        LOW: begin
          if (rise) begin
            period_meas_d = cnt_q;
            high_meas_d   = high_q;
            meas_valid_d  = 1'b1;
            state_d       = HIGH;
          end else if (saturate) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARM;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pcnt_q        <= '0;
      cnt_q         <= '0;
      high_q        <= '0;
      period_meas_q <= '0;
      high_meas_q   <= '0;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcnt_q        <= pcnt_d;
      cnt_q         <= cnt_d;
      high_q        <= high_d;
      period_meas_q <= period_meas_d;
      high_meas_q   <= high_meas_d;
      meas_valid_q  <= meas_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.period_meas = period_meas_q;
  assign bus.high_meas   = high_meas_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int W  = 8;
  localparam int SS = 2;
  // Edges from the pad sample to the edge where the capture logic acts.
  localparam int D  = SS + 1;
  localparam int CNT_LIMIT = 1 << W;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_WIDTH(W)) bus ();

  pwm_capture #(
    .CNT_WIDTH  (W),
    .SYNC_STAGES(SS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pad history plus "when did the current period start".
  int           n = 0;
  logic [D:0]   hist = '0;
  int           mode = 0;      // 0 off, 1 waiting for first edge, 2 measuring
  int           c0 = 0;
  int           high_v = 0;
  bit           seen_fall = 1'b0;
  logic [W-1:0] m_period = '0;
  logic [W-1:0] m_high = '0;
  logic         m_valid = 1'b0;
  logic         m_timeout = 1'b0;

  int val_q[$];
  int tmo_q[$];

  task automatic model_update();
    int  p;
    int  cv;
    int  nv;
    bit  r;
    bit  f;
    n++;
    m_valid   = 1'b0;
    m_timeout = 1'b0;
    if (reset) begin
      hist     = '0;
      mode     = 0;
      m_period = '0;
      m_high   = '0;
    end else begin
      r    = hist[D-1] & ~hist[D];
      f    = ~hist[D-1] & hist[D];
      hist = {hist[D-1:0], bus.pwm_in};
      p    = int'(bus.prescaler);
      if (!bus.enable) begin
        mode = 0;
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (r) begin
          c0 = n; seen_fall = 1'b0; mode = 2;
        end
      end else begin
        // Ticks counted so far in this period, and after this clock.
        cv = (n - c0) / (p + 1);
        nv = (n + 1 - c0) / (p + 1);
        if (r) begin
          m_period  = W'(cv);
          m_high    = seen_fall ? W'(high_v) : W'(cv);
          m_valid   = 1'b1;
          c0        = n;
          seen_fall = 1'b0;
        end else if (nv == CNT_LIMIT) begin
          m_timeout = 1'b1;
          mode      = 1;
        end else if (f && !seen_fall) begin
          high_v    = cv;
          seen_fall = 1'b1;
        end
      end
    end
  endtask

  task automatic check_out();
    vectors++;
    if (bus.meas_valid !== m_valid || bus.timeout !== m_timeout ||
        bus.period_meas !== m_period || bus.high_meas !== m_high) begin
      miscompares++;
      $display("FAIL outputs @edge %0d: dut valid=%b timeout=%b period=%0d high=%0d, expected valid=%b timeout=%b period=%0d high=%0d",
               n, bus.meas_valid, bus.timeout, bus.period_meas, bus.high_meas,
               m_valid, m_timeout, m_period, m_high);
    end
    if (bus.meas_valid === 1'b1) val_q.push_back(n);
    if (bus.timeout === 1'b1) tmo_q.push_back(n);
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Called just after a falling edge: drive, let the DUT and model take
  // the rising edge, then compare at the following falling edge.
  task automatic step(input logic pin);
    bus.pwm_in = pin;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_out();
  endtask

  task automatic hold(input logic pin, input int cycles);
    for (int i = 0; i < cycles; i++) step(pin);
  endtask

  task automatic pwm(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic rearm(input int pre);
    bus.enable = 1'b0;
    hold(bus.pwm_in, 2);
    bus.prescaler = W'(pre);
    bus.enable = 1'b1;
    hold(bus.pwm_in, 2);
  endtask

  task automatic clear_seg();
    val_q.delete();
    tmo_q.delete();
  endtask

  initial begin
    int e1;
    int e2;
    int hi;
    int lo;
    int sel;

    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.prescaler = '0;
    bus.pwm_in    = 1'b0;

    // Reset state.
    hold(1'b0, 3);
    check_lit("reset period_meas", int'(bus.period_meas), 0);
    check_lit("reset high_meas", int'(bus.high_meas), 0);
    check_lit("reset meas_valid", int'(bus.meas_valid), 0);
    check_lit("reset timeout", int'(bus.timeout), 0);
    reset = 1'b0;

    // 10/3 waveform, prescaler 0: arming edge, then three measured periods.
    bus.enable = 1'b1;
    hold(1'b0, 3);
    clear_seg();
    pwm(3, 7, 1);
    e1 = n + 1;
    pwm(3, 7, 3);
    hold(1'b0, 5);
    check_lit("10/3 valid count", val_q.size(), 3);
    check_lit("10/3 period", int'(bus.period_meas), 10);
    check_lit("10/3 high", int'(bus.high_meas), 3);
    check_lit("valid latency", (val_q.size() > 0) ? val_q[0] - e1 : -1, 3);

    // Prescaler 1, 40/10 waveform.
    rearm(1);
    clear_seg();
    pwm(10, 30, 3);
    hold(1'b0, 5);
    check_lit("presc1 valid count", val_q.size(), 2);
    check_lit("presc1 period", int'(bus.period_meas), 20);
    check_lit("presc1 high", int'(bus.high_meas), 5);

    // Held low after a single edge: timeout, re-arm, repeat.
    rearm(0);
    clear_seg();
    e1 = n + 1;
    hold(1'b1, 3);
    hold(1'b0, 300);
    e2 = n + 1;
    hold(1'b1, 3);
    hold(1'b0, 300);
    check_lit("low timeout count", tmo_q.size(), 2);
    check_lit("timeout latency 1", (tmo_q.size() > 0) ? tmo_q[0] - e1 : -1, D + CNT_LIMIT - 1);
    check_lit("timeout latency 2", (tmo_q.size() > 1) ? tmo_q[1] - e2 : -1, D + CNT_LIMIT - 1);
    check_lit("low timeout no valid", val_q.size(), 0);
    check_lit("timeout keeps period", int'(bus.period_meas), 20);
    check_lit("timeout keeps high", int'(bus.high_meas), 5);

    // Constant high, then the 10/3 waveform resumes.
    rearm(0);
    clear_seg();
    hold(1'b1, 600);
    check_lit("high timeout count", tmo_q.size(), 1);
    check_lit("high no valid", val_q.size(), 0);
    pwm(3, 7, 4);
    hold(1'b0, 5);
    check_lit("resume valid count", val_q.size(), 2);
    check_lit("resume period", int'(bus.period_meas), 10);
    check_lit("resume high", int'(bus.high_meas), 3);

    // Enable dropped mid-period for 5 clocks.
    rearm(0);
    pwm(4, 8, 3);
    hold(1'b1, 4);
    hold(1'b0, 2);
    bus.enable = 1'b0;
    hold(1'b0, 5);
    bus.enable = 1'b1;
    clear_seg();
    hold(1'b0, 3);
    hold(1'b1, 5);
    hold(1'b0, 20);
    check_lit("after enable no valid", val_q.size(), 0);
    check_lit("after enable held period", int'(bus.period_meas), 12);
    check_lit("after enable held high", int'(bus.high_meas), 4);
    hold(1'b1, 3);
    hold(1'b0, 10);
    check_lit("after enable valid count", val_q.size(), 1);
    check_lit("after enable period", int'(bus.period_meas), 25);
    check_lit("after enable high", int'(bus.high_meas), 5);

    // Reset while in the low phase.
    pwm(3, 7, 2);
    hold(1'b1, 3);
    hold(1'b0, 5);
    reset = 1'b1;
    step(1'b0);
    check_lit("mid reset period", int'(bus.period_meas), 0);
    check_lit("mid reset high", int'(bus.high_meas), 0);
    check_lit("mid reset valid", int'(bus.meas_valid), 0);
    check_lit("mid reset timeout", int'(bus.timeout), 0);
    reset = 1'b0;
    clear_seg();
    hold(1'b0, 4);
    pwm(3, 7, 1);
    hold(1'b0, 20);
    check_lit("post reset no valid", val_q.size(), 0);

    // Counter limit: 255 is measurable, 256 is a timeout.
    rearm(0);
    clear_seg();
    pwm(1, 254, 3);
    check_lit("255 valid count", val_q.size(), 2);
    check_lit("255 period", int'(bus.period_meas), 255);
    check_lit("255 high", int'(bus.high_meas), 1);
    rearm(0);
    clear_seg();
    pwm(1, 255, 3);
    hold(1'b0, 20);
    check_lit("256 no valid", val_q.size(), 0);
    check_lit("256 timeout count", tmo_q.size(), 3);
    check_lit("256 keeps period", int'(bus.period_meas), 255);

    // Randomized waveforms, prescalers, enable drops and resets.
    for (int it = 0; it < 60; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        rearm(int'($urandom_range(0, 3)));
      end else if (sel == 2) begin
        reset = 1'b1;
        step(bus.pwm_in);
        reset = 1'b0;
      end else if (sel == 3) begin
        bus.enable = 1'b0;
        hold(bus.pwm_in, int'($urandom_range(1, 6)));
        bus.enable = 1'b1;
      end
      hi = int'($urandom_range(1, 25));
      lo = int'($urandom_range(1, 25));
      if (sel == 4 && bus.prescaler == '0) lo = int'($urandom_range(240, 270));
      pwm(hi, lo, int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
